// File: rtl/fft_sequencer.sv
// FFT stage sequencer: drives a shared advance strobe, per-stage butterfly selects
// and twiddle addresses for a LOG2N-stage pipelined radix-2 FFT, and tags the
// bit-reversed results leaving the last stage.
module fft_sequencer #(
  parameter int unsigned FFT_N     = 1024,
  parameter int unsigned STAGE_LAT = 1,
  localparam int unsigned LOG2N    = $clog2(FFT_N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     stage_enable,
  output logic [LOG2N-1:0]         stage_ctrl,
  output logic [LOG2N*LOG2N-1:0]   stage_addr,
  output logic                     out_valid,
  output logic                     out_sof,
  output logic                     out_last,
  output logic [LOG2N-1:0]         out_index,
  output logic                     busy,
  output logic                     err_overrun
);

  // Pipeline fill latency: first sample reaches the last-stage output after TL enables.
  localparam int unsigned TL = FFT_N - 1 + LOG2N * STAGE_LAT;
  localparam int unsigned EW = $clog2(TL + 1);

  localparam logic [EW-1:0]    TL_E    = EW'(TL);
  localparam logic [EW-1:0]    TL_LAST = EW'(TL - 1);
  localparam logic [EW-1:0]    E_ONE   = EW'(1);
  localparam logic [LOG2N-1:0] F_ONE   = LOG2N'(1);
  localparam logic [LOG2N-1:0] TL_F    = LOG2N'(TL % FFT_N);

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  state_e           state_q;
  logic [EW-1:0]    e_q;    // enable count since first sample, saturating at TL
  logic [LOG2N-1:0] f_q;    // enable count modulo FFT_N, never saturates
  logic [EW-1:0]    fc_q;   // enables spent in FLUSH
  logic [LOG2N-1:0] cs;
  logic [LOG2N-1:0] out_bin;

  // Enable-count offset at which stage s starts seeing valid data.
  function automatic int unsigned stage_offset(input int unsigned s);
    int unsigned o;
    o = 0;
    for (int unsigned k = 1; k < s; k++) begin
      o = o + (32'd1 << (LOG2N - k)) + STAGE_LAT;
    end
    return o;
  endfunction

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // FLUSH drains the pipeline autonomously; reset forces the strobe low.
  assign stage_enable = rst_n & ((state_q == StFlush) | in_valid);

  // Result bin position relative to the pipeline fill latency.
  assign out_bin = f_q - TL_F;

  // Per-stage local count selects the butterfly leg and twiddle address.
  always_comb begin
    stage_ctrl = '0;
    stage_addr = '0;
    cs         = '0;
    for (int unsigned s = 1; s <= LOG2N; s++) begin
      cs = f_q - LOG2N'(stage_offset(s) % FFT_N);
      if (32'(e_q) >= stage_offset(s)) begin
        stage_ctrl[s-1] = cs[LOG2N-s];
        stage_addr[(s-1)*LOG2N +: LOG2N] = cs & LOG2N'((32'd1 << (LOG2N - s)) - 32'd1);
      end
    end
  end

  // Sequencer FSM with counters and registered result tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      e_q         <= '0;
      f_q         <= '0;
      fc_q        <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_last    <= 1'b0;
      out_index   <= '0;
      busy        <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (stage_enable) begin
        out_valid <= (e_q >= TL_E);
        out_sof   <= (e_q >= TL_E) && (out_bin == '0);
        out_last  <= (state_q == StFlush) && (fc_q == TL_LAST);
        if (e_q >= TL_E) begin
          out_index <= bit_rev(out_bin);
        end
        f_q <= f_q + F_ONE;
        if (e_q != TL_E) begin
          e_q <= e_q + E_ONE;
        end
      end else begin
        // Gaps stall the pipeline: no result this cycle, index held.
        out_valid <= 1'b0;
        out_sof   <= 1'b0;
        out_last  <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q <= in_last ? StFlush : StRun;
            busy    <= 1'b1;
          end
        end
        StRun: begin
          if (in_valid && in_last) begin
            state_q <= StFlush;
          end
        end
        StFlush: begin
          if (in_valid) begin
            err_overrun <= 1'b1;
          end
          if (fc_q == TL_LAST) begin
            // Final result emitted: clear all counts for the next frame.
            state_q <= StIdle;
            busy    <= 1'b0;
            e_q     <= '0;
            f_q     <= '0;
            fc_q    <= '0;
          end else begin
            fc_q <= fc_q + E_ONE;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
